reorder_buffer_mc: RTL
======================

Name: reorder_buffer_mc

Overview:
Parametrised successor of the single-commit reorder buffer. It is an in-order FIFO of in-flight instructions with multiple writeback ports and in-order commit of up to CMT_W entries per cycle. It also bypasses same-cycle writebacks on its operand-ready ports. It sits between decoder/issue, the CDB/LSB writeback paths, the register file and the fetch/RS/LSB flush network.

Parameters:
DEPTH, 32, slot count; power of 2; slot 0 reserved as "no tag", so capacity is DEPTH-1
IDX_W, $clog2(DEPTH), tag width
DAT_W, 32, data/pc width
REG_BIT, 5, architectural register index width
OP_W, 6, opcode width
WB_N, 2, writeback ports (port 0 = CDB, port 1 = LSB)
CMT_W, 2, maximum commits per cycle

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  global stall; 0 freezes all state
is_en_i  in  1  dispatch request
is_tp_i  in  2  type: 00 branch, 01 store, 10 load, 11 alu
is_op_i  in  OP_W  opcode
is_rd_i  in  REG_BIT  destination register
is_pc_i  in  DAT_W  instruction pc
is_pbr_i  in  1  predicted taken
is_tag_o  out  IDX_W  tag the next dispatch receives (current tail)
wb_en_i  in  WB_N  per-port writeback valid
wb_q_i  in  WB_N*IDX_W  per-port tag
wb_v_i  in  WB_N*DAT_W  per-port value
wb_cbr_i  in  WB_N  computed taken (used by branches)
wb_cbt_i  in  WB_N*DAT_W  computed target
rf_en_o  out  CMT_W  per-lane register commit valid
rf_rd_o  out  CMT_W*REG_BIT  per-lane rd
rf_q_o  out  CMT_W*IDX_W  per-lane tag
rf_v_o  out  CMT_W*DAT_W  per-lane value
lsb_cmt_o  out  1  pulse: commit oldest store
rf_reqq_i  in  2*IDX_W  operand tag queries j,k
rf_rdy_o  out  2  query ready (bypassed)
rf_rdyv_o  out  2*DAT_W  query value (bypassed)
br_flag  out  1  mispredict flush pulse
br_abr  out  1  actual taken
br_tpc  out  DAT_W  pc of the mispredicted branch
br_cbt  out  DAT_W  computed target
full  out  1  count == DEPTH-1
empty  out  1  count == 0
count_o  out  IDX_W  occupied entries

Behaviour:
- Reset (async) or br_flag high at a clock edge: head=tail=1, count=0, every ready bit cleared. All outputs go to 0; empty=1. In the br_flag cycle, dispatch and writeback are ignored.
- Index advance: next(x) = (x==DEPTH-1) ? 1 : x+1. Slot 0 is never allocated.
- Dispatch: accepted when is_en_i && !full && en. The entry is written at tail with ready=0 and tail advances. is_tag_o reflects the tail before the edge.
- Writeback: for each port p with wb_en_i[p] and wb_q_i[p] != 0, set ready, v, cbr and cbt. If two ports name the same tag in one cycle, the higher index wins. A writeback to a free slot is harmless.
- Query: rf_rdy_o/rf_rdyv_o are combinational. Priority: a same-cycle writeback with a matching tag (highest port first), else the stored ready/v. Tag 0 always returns rdy=0.
- Commit selection (combinational, registered into outputs, 1-cycle latency). Walk lanes 0..CMT_W-1 from head. Entry i commits if all earlier lanes committed, it is occupied, and it is ready, or it is a store (stores need no ready). Stop after:
  - a second store in the same cycle (at most one store per cycle);
  - any branch (at most one branch per cycle, and it is always the last lane taken).
- Committed alu/load entries: rf_en_o[lane]=1 with rd/tag/v. A branch with op==JALR also writes rd. A store pulses lsb_cmt_o. A branch with pbr != cbr raises br_flag for one cycle with br_abr/br_tpc/br_cbt; younger entries are discarded by the flush.
- Count: count_next = count + accepted_dispatch - commits. full and empty are registered from count_next. Simultaneous dispatch into a full ROB while commit frees a slot is rejected that cycle (full is the registered value).
- Registered pulse outputs (rf_en_o, lsb_cmt_o, br_flag) default to 0 every enabled cycle. When en=0, outputs hold.

Decomposition:
- Shared package rob_pkg:
  - type codes TP_BR/TP_ST/TP_LD/TP_ALU;
  - JALR opcode constant;
  - next_idx function;
  - entry struct {op, tp, rd, v, pc, pbr, cbr, cbt, ready}.
- One sub-module, rob_commit_sel: combinational lane selection producing commit mask, store pulse, branch lane and mispredict flag from the CMT_W head entries.

Test Plan:
1. Dispatch 3 alu ops (tags 1,2,3); writeback tag 2 then tag 1 on port 0 with v=0x11, 0x22 -> the cycle after both are ready, rf_en_o=2'b11 with tags 1,2; tag 3 commits later; count returns to 0.
2. Fill 31 entries -> full=1 and the 32nd dispatch is ignored. Commit one -> full=0. The next dispatch receives tag 1 (wrap skips 0).
3. Head is a store followed by a store, both unready -> only one lsb_cmt_o pulse per cycle, over 2 consecutive cycles.
4. Branch at tag 4 with pbr=1, wb cbr=0, cbt=0x1000, pc=0x80 -> br_flag=1, br_abr=0, br_tpc=0x80, br_cbt=0x1000 for one cycle. The next cycle: empty=1, head=tail=1.
5. Query tag 5 while port 1 writes tag 5 with v=0xABCD in the same cycle -> rf_rdy_o=1, rf_rdyv_o=0xABCD combinationally. Ports 0 and 1 both write tag 5 -> the port 1 value is stored.
6. Assert rst mid-commit, asynchronously between edges -> outputs clear immediately; dispatch resumes at tag 1 after rst deasserts.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types, constants and helpers for the multi-commit reorder buffer.
package rob_pkg;

  localparam int ROB_OP_W    = 6;
  localparam int ROB_REG_BIT = 5;
  localparam int ROB_DAT_W   = 32;

  typedef enum logic [1:0] {
    TP_BR  = 2'b00,
    TP_ST  = 2'b01,
    TP_LD  = 2'b10,
    TP_ALU = 2'b11
  } rob_tp_e;

  // Branch opcode that also links into rd.
  localparam logic [ROB_OP_W-1:0] OP_JALR = 6'h19;

  // One in-flight instruction. Field widths follow the package widths,
  // which are the defaults of the top-level parameters.
  typedef struct packed {
    logic [ROB_OP_W-1:0]    op;
    rob_tp_e                tp;
    logic [ROB_REG_BIT-1:0] rd;
    logic [ROB_DAT_W-1:0]   v;
    logic [ROB_DAT_W-1:0]   pc;
    logic                   pbr;
    logic                   cbr;
    logic [ROB_DAT_W-1:0]   cbt;
    logic                   ready;
  } rob_entry_t;

  // Slice of an entry the commit selector looks at.
  typedef struct packed {
    rob_tp_e tp;
    logic    is_jalr;
    logic    pbr;
    logic    cbr;
    logic    ready;
  } rob_sel_t;

  // Circular index advance; slot 0 is the "no tag" value and is skipped.
  function automatic int unsigned next_idx(input int unsigned x, input int unsigned depth);
    return (x == depth - 1) ? 32'd1 : x + 32'd1;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Picks which of the CMT_W oldest entries retire this cycle: in order,
// at most one store, and a branch always ends the group.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int CMT_W  = 2,
  parameter int LANE_W = 1,
  parameter int CNT_W  = 5
) (
  input  rob_sel_t              ent_i [CMT_W],
  input  logic [CMT_W-1:0]      occ_i,
  output logic [CMT_W-1:0]      cmt_o,
  output logic [CMT_W-1:0]      rf_wr_o,
  output logic                  st_o,
  output logic                  br_o,
  output logic [LANE_W-1:0]     br_lane_o,
  output logic                  mis_o,
  output logic [CNT_W-1:0]      n_cmt_o
);

  logic stop;
  logic st_seen;

  // Walk lanes from the head and stop at the first lane that cannot retire.
  always_comb begin
    cmt_o     = '0;
    rf_wr_o   = '0;
    st_o      = 1'b0;
    br_o      = 1'b0;
    br_lane_o = '0;
    mis_o     = 1'b0;
    n_cmt_o   = '0;
    stop      = 1'b0;
    st_seen   = 1'b0;
    for (int i = 0; i < CMT_W; i++) begin
      if (!stop) begin
        if (!occ_i[i] || !(ent_i[i].ready || ent_i[i].tp == TP_ST)) begin
          stop = 1'b1;
        end else if (ent_i[i].tp == TP_ST && st_seen) begin
          stop = 1'b1;
        end else begin
          cmt_o[i] = 1'b1;
          n_cmt_o  = n_cmt_o + CNT_W'(1);
          case (ent_i[i].tp)
            TP_ST: begin
              st_seen = 1'b1;
              st_o    = 1'b1;
            end
            TP_BR: begin
              br_o       = 1'b1;
              br_lane_o  = LANE_W'(i);
              mis_o      = ent_i[i].pbr != ent_i[i].cbr;
              rf_wr_o[i] = ent_i[i].is_jalr;
              stop       = 1'b1;
            end
            default: rf_wr_o[i] = 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mc.sv
// In-order reorder buffer with multiple writeback ports, bypassed operand
// queries and up to CMT_W in-order commits per cycle.
module reorder_buffer_mc
  import rob_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int DAT_W   = 32,
  parameter int REG_BIT = 5,
  parameter int OP_W    = 6,
  parameter int WB_N    = 2,
  parameter int CMT_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     is_en_i,
  input  logic [1:0]               is_tp_i,
  input  logic [OP_W-1:0]          is_op_i,
  input  logic [REG_BIT-1:0]       is_rd_i,
  input  logic [DAT_W-1:0]         is_pc_i,
  input  logic                     is_pbr_i,
  output logic [IDX_W-1:0]         is_tag_o,
  input  logic [WB_N-1:0]          wb_en_i,
  input  logic [WB_N*IDX_W-1:0]    wb_q_i,
  input  logic [WB_N*DAT_W-1:0]    wb_v_i,
  input  logic [WB_N-1:0]          wb_cbr_i,
  input  logic [WB_N*DAT_W-1:0]    wb_cbt_i,
  output logic [CMT_W-1:0]         rf_en_o,
  output logic [CMT_W*REG_BIT-1:0] rf_rd_o,
  output logic [CMT_W*IDX_W-1:0]   rf_q_o,
  output logic [CMT_W*DAT_W-1:0]   rf_v_o,
  output logic                     lsb_cmt_o,
  input  logic [2*IDX_W-1:0]       rf_reqq_i,
  output logic [1:0]               rf_rdy_o,
  output logic [2*DAT_W-1:0]       rf_rdyv_o,
  output logic                     br_flag,
  output logic                     br_abr,
  output logic [DAT_W-1:0]         br_tpc,
  output logic [DAT_W-1:0]         br_cbt,
  output logic                     full,
  output logic                     empty,
  output logic [IDX_W-1:0]         count_o
);

  localparam int LANE_W = (CMT_W > 1) ? $clog2(CMT_W) : 1;

  rob_entry_t               mem_q [DEPTH];
  rob_entry_t               mem_d [DEPTH];
  logic [IDX_W-1:0]         head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic                     full_q, full_d, empty_q, empty_d;
  logic [CMT_W-1:0]         rf_en_q, rf_en_d;
  logic [CMT_W*REG_BIT-1:0] rf_rd_q, rf_rd_d;
  logic [CMT_W*IDX_W-1:0]   rf_q_q, rf_q_d;
  logic [CMT_W*DAT_W-1:0]   rf_v_q, rf_v_d;
  logic                     lsb_q, lsb_d, br_flag_q, br_flag_d, br_abr_q, br_abr_d;
  logic [DAT_W-1:0]         br_tpc_q, br_tpc_d, br_cbt_q, br_cbt_d;

  logic [IDX_W-1:0]  lane_idx [CMT_W];
  rob_entry_t        head_ent [CMT_W];
  rob_sel_t          sel_in   [CMT_W];
  logic [CMT_W-1:0]  occ, cmt, rf_wr;
  logic              sel_st, sel_br, sel_mis, acc;
  logic [LANE_W-1:0] br_lane;
  logic [IDX_W-1:0]  n_cmt, walk, qtag;

  // Tags and contents of the CMT_W oldest slots starting at head.
  always_comb begin
    walk = head_q;
    for (int i = 0; i < CMT_W; i++) begin
      lane_idx[i]       = walk;
      head_ent[i]       = mem_q[walk];
      occ[i]            = count_q > IDX_W'(i);
      sel_in[i].tp      = head_ent[i].tp;
      sel_in[i].is_jalr = head_ent[i].op == OP_JALR;
      sel_in[i].pbr     = head_ent[i].pbr;
      sel_in[i].cbr     = head_ent[i].cbr;
      sel_in[i].ready   = head_ent[i].ready;
      walk              = IDX_W'(next_idx(32'(walk), DEPTH));
    end
  end

  rob_commit_sel #(.CMT_W(CMT_W), .LANE_W(LANE_W), .CNT_W(IDX_W)) u_sel (
    .ent_i     (sel_in),
    .occ_i     (occ),
    .cmt_o     (cmt),
    .rf_wr_o   (rf_wr),
    .st_o      (sel_st),
    .br_o      (sel_br),
    .br_lane_o (br_lane),
    .mis_o     (sel_mis),
    .n_cmt_o   (n_cmt)
  );

  // Operand queries: same-cycle writebacks (highest port last, so it wins) override storage.
  always_comb begin
    rf_rdy_o  = '0;
    rf_rdyv_o = '0;
    qtag      = '0;
    for (int j = 0; j < 2; j++) begin
      qtag                       = rf_reqq_i[j*IDX_W +: IDX_W];
      rf_rdy_o[j]                = mem_q[qtag].ready;
      rf_rdyv_o[j*DAT_W +: DAT_W] = mem_q[qtag].v;
      for (int p = 0; p < WB_N; p++) begin
        if (wb_en_i[p] && wb_q_i[p*IDX_W +: IDX_W] == qtag) begin
          rf_rdy_o[j]                 = 1'b1;
          rf_rdyv_o[j*DAT_W +: DAT_W] = wb_v_i[p*DAT_W +: DAT_W];
        end
      end
      if (qtag == '0) begin
        rf_rdy_o[j]                 = 1'b0;
        rf_rdyv_o[j*DAT_W +: DAT_W] = '0;
      end
    end
  end

  // Next state: flush on a pending mispredict, otherwise writeback, dispatch and commit.
  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    full_d    = full_q;
    empty_d   = empty_q;
    rf_en_d   = rf_en_q;
    rf_rd_d   = rf_rd_q;
    rf_q_d    = rf_q_q;
    rf_v_d    = rf_v_q;
    lsb_d     = lsb_q;
    br_flag_d = br_flag_q;
    br_abr_d  = br_abr_q;
    br_tpc_d  = br_tpc_q;
    br_cbt_d  = br_cbt_q;
    acc       = 1'b0;
    if (en) begin
      rf_en_d   = '0;
      lsb_d     = 1'b0;
      br_flag_d = 1'b0;
      if (br_flag_q) begin
        for (int k = 0; k < DEPTH; k++) mem_d[k].ready = 1'b0;
        head_d   = IDX_W'(1);
        tail_d   = IDX_W'(1);
        count_d  = '0;
        full_d   = 1'b0;
        empty_d  = 1'b1;
        rf_rd_d  = '0;
        rf_q_d   = '0;
        rf_v_d   = '0;
        br_abr_d = 1'b0;
        br_tpc_d = '0;
        br_cbt_d = '0;
      end else begin
        for (int p = 0; p < WB_N; p++) begin
          if (wb_en_i[p] && wb_q_i[p*IDX_W +: IDX_W] != '0) begin
            mem_d[wb_q_i[p*IDX_W +: IDX_W]].ready = 1'b1;
            mem_d[wb_q_i[p*IDX_W +: IDX_W]].v     = wb_v_i[p*DAT_W +: DAT_W];
            mem_d[wb_q_i[p*IDX_W +: IDX_W]].cbr   = wb_cbr_i[p];
            mem_d[wb_q_i[p*IDX_W +: IDX_W]].cbt   = wb_cbt_i[p*DAT_W +: DAT_W];
          end
        end
        acc = is_en_i && !full_q;
        if (acc) begin
          mem_d[tail_q] = '{op: is_op_i, tp: rob_tp_e'(is_tp_i), rd: is_rd_i, v: '0,
                            pc: is_pc_i, pbr: is_pbr_i, cbr: 1'b0, cbt: '0, ready: 1'b0};
          tail_d = IDX_W'(next_idx(32'(tail_q), DEPTH));
        end
        for (int i = 0; i < CMT_W; i++) begin
          if (cmt[i]) head_d = IDX_W'(next_idx(32'(lane_idx[i]), DEPTH));
          rf_rd_d[i*REG_BIT +: REG_BIT] = head_ent[i].rd;
          rf_q_d[i*IDX_W +: IDX_W]      = lane_idx[i];
          rf_v_d[i*DAT_W +: DAT_W]      = head_ent[i].v;
        end
        rf_en_d = rf_wr;
        lsb_d   = sel_st;
        if (sel_br && sel_mis) begin
          br_flag_d = 1'b1;
          br_abr_d  = head_ent[br_lane].cbr;
          br_tpc_d  = head_ent[br_lane].pc;
          br_cbt_d  = head_ent[br_lane].cbt;
        end
        count_d = count_q + IDX_W'(acc) - n_cmt;
        full_d  = count_d == IDX_W'(DEPTH - 1);
        empty_d = count_d == '0;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      head_q    <= IDX_W'(1);
      tail_q    <= IDX_W'(1);
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rf_en_q   <= '0;
      rf_rd_q   <= '0;
      rf_q_q    <= '0;
      rf_v_q    <= '0;
      lsb_q     <= 1'b0;
      br_flag_q <= 1'b0;
      br_abr_q  <= 1'b0;
      br_tpc_q  <= '0;
      br_cbt_q  <= '0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_q_q    <= rf_q_d;
      rf_v_q    <= rf_v_d;
      lsb_q     <= lsb_d;
      br_flag_q <= br_flag_d;
      br_abr_q  <= br_abr_d;
      br_tpc_q  <= br_tpc_d;
      br_cbt_q  <= br_cbt_d;
    end
  end

  assign is_tag_o  = tail_q;
  assign count_o   = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign rf_en_o   = rf_en_q;
  assign rf_rd_o   = rf_rd_q;
  assign rf_q_o    = rf_q_q;
  assign rf_v_o    = rf_v_q;
  assign lsb_cmt_o = lsb_q;
  assign br_flag   = br_flag_q;
  assign br_abr    = br_abr_q;
  assign br_tpc    = br_tpc_q;
  assign br_cbt    = br_cbt_q;

endmodule
